// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned memory requests with one transaction
// in flight and buffers returned instructions in a small FIFO toward the core.
module instr_fetch_unit #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] boot_addr_i,
  input  logic        fetch_enable_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        busy_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     req_addr_q;
  logic            discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [63:0]     fifo_mem [FIFO_DEPTH];
  logic            push, pop, issue_ok;

  logic            unused_addr_bits;
  assign unused_addr_bits = ^{boot_addr_i[1:0], branch_addr_i[1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A response is buffered only if no redirect has happened since its request was presented.
  assign push = (state_q == S_WAIT) && instr_rvalid_i && !discard_q && !branch_i;
  assign pop  = valid_o && ready_i;

  assign valid_o      = (count_q != '0);
  assign instr_o      = valid_o ? fifo_mem[rd_ptr_q][31:0]  : '0;
  assign pc_o         = valid_o ? fifo_mem[rd_ptr_q][63:32] : '0;
  assign instr_req_o  = (state_q == S_REQ);
  assign instr_addr_o = req_addr_q;
  assign busy_o       = (state_q != S_IDLE);

  always_comb begin
    count_d = count_q;
    if (branch_i)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  // Issue decisions use next-cycle occupancy so a same-cycle pop frees a slot at once.
  assign issue_ok = fetch_enable_i && (count_d < CW'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue_ok) state_d = S_REQ;
      S_REQ:   if (instr_gnt_i) state_d = S_WAIT;
      S_WAIT:  if (instr_rvalid_i) state_d = issue_ok ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // After a branch in REQ the register already holds the target, so the grant must not bump it.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (branch_i)
      fetch_addr_d = {branch_addr_i[31:2], 2'b00};
    else if ((state_q == S_REQ) && instr_gnt_i && !discard_q)
      fetch_addr_d = fetch_addr_q + 32'd4;
  end

  always_comb begin
    discard_d = discard_q;
    if ((state_q == S_WAIT) && instr_rvalid_i)
      discard_d = 1'b0;
    if (branch_i && ((state_q == S_REQ) || ((state_q == S_WAIT) && !instr_rvalid_i)))
      discard_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= {boot_addr_i[31:2], 2'b00};
      req_addr_q   <= {boot_addr_i[31:2], 2'b00};
      discard_q    <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      discard_q    <= discard_d;
      count_q      <= count_d;
      if ((state_q != S_REQ) && (state_d == S_REQ))
        req_addr_q <= fetch_addr_d;
      if (branch_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      fifo_mem[wr_ptr_q] <= {req_addr_q, instr_rdata_i};
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: the bench plays the instruction memory and
// tracks a transaction-level model of expected request addresses and delivered instructions.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i, fetch_enable_i, instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic        branch_i, valid_o, ready_i, busy_o;
  logic [31:0] boot_addr_i, instr_addr_o, instr_rdata_i, branch_addr_i, instr_o, pc_o;

  always #5 clk = ~clk;

  instr_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .boot_addr_i(boot_addr_i), .fetch_enable_i(fetch_enable_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o),
    .pc_o(pc_o), .busy_o(busy_o)
  );

  int num_checks = 0;
  int num_pass = 0;

  logic        drv_rst = 1'b1, drv_fe = 1'b0, drv_ready = 1'b0, drv_branch = 1'b0;
  logic [31:0] drv_baddr = '0, drv_boot = '0;
  int          gnt_delay = 0, rv_delay = 0;
  bit          late_rvalid = 0;

  logic [63:0] exp_q[$];
  logic [31:0] req_log[$], pop_log[$];
  bit          req_open = 0, req_stale = 0, mem_pending = 0, pend_stale = 0;
  bit          prev_rst = 1, prev_fe = 0, pushed_since_reset = 0;
  int          req_age = 0, pend_age = 0;
  logic [31:0] req_addr_seen = '0, pend_addr = '0, exp_fetch = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] log_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    if (obs === exp) num_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic observeOutputs();
    if (prev_rst) begin
      checkOutput("req_after_reset", instr_req_o, 1'b0);
    end else if (instr_req_o && !req_open) begin
      checkOutput("req_addr", instr_addr_o, exp_fetch);
      checkOutput("req_one_outstanding", mem_pending, 1'b0);
      checkOutput("req_fifo_room", exp_q.size() < DEPTH, 1'b1);
      checkOutput("req_enabled", prev_fe, 1'b1);
      req_log.push_back(instr_addr_o);
      req_open      = 1;
      req_stale     = 0;
      req_age       = 0;
      req_addr_seen = instr_addr_o;
      exp_fetch     = instr_addr_o + 32'd4;
    end else if (req_open) begin
      checkOutput("req_held", instr_req_o, 1'b1);
      checkOutput("req_addr_stable", instr_addr_o, req_addr_seen);
      if (!instr_req_o) req_open = 0;
    end
    if (exp_q.size() != 0) begin
      checkOutput("valid", valid_o, 1'b1);
      checkOutput("instr", instr_o, exp_q[0][31:0]);
      checkOutput("pc", pc_o, exp_q[0][63:32]);
    end else begin
      checkOutput("valid_empty", valid_o, 1'b0);
      if (!pushed_since_reset) begin
        checkOutput("instr_reset", instr_o, 32'h0);
        checkOutput("pc_reset", pc_o, 32'h0);
      end
    end
    checkOutput("busy", busy_o, req_open || mem_pending);
  endtask

  task automatic applyStimulus();
    rst_i          = drv_rst;
    boot_addr_i    = drv_boot;
    fetch_enable_i = drv_fe;
    ready_i        = drv_ready;
    branch_i       = drv_branch;
    branch_addr_i  = drv_baddr;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = $urandom;
    if (instr_req_o && !mem_pending)
      instr_gnt_i = (gnt_delay < 0) ? ($urandom_range(0, 3) != 0) : (req_age >= gnt_delay);
    if (mem_pending) begin
      instr_rvalid_i = (rv_delay < 0) ? ($urandom_range(0, 2) == 0) : (pend_age >= rv_delay);
      if (instr_rvalid_i) instr_rdata_i = mem_data(pend_addr);
    end else if (late_rvalid) begin
      instr_rvalid_i = 1'b1;
    end else if (rv_delay < 0) begin
      instr_rvalid_i = ($urandom_range(0, 19) == 0);
    end
  endtask

  task automatic updateModel();
    bit resp;
    if (drv_rst) begin
      exp_q.delete();
      req_open           = 0;
      mem_pending        = 0;
      pushed_since_reset = 0;
      exp_fetch          = {drv_boot[31:2], 2'b00};
    end else begin
      resp = mem_pending && instr_rvalid_i;
      if (exp_q.size() != 0 && drv_ready && !drv_branch) begin
        pop_log.push_back(exp_q[0][63:32]);
        void'(exp_q.pop_front());
      end
      if (resp) begin
        if (!pend_stale && !drv_branch) begin
          exp_q.push_back({pend_addr, instr_rdata_i});
          pushed_since_reset = 1;
        end
        mem_pending = 0;
      end
      if (drv_branch) begin
        exp_q.delete();
        exp_fetch = {drv_baddr[31:2], 2'b00};
        if (req_open) req_stale = 1;
        if (mem_pending) pend_stale = 1;
      end
      if (req_open && instr_gnt_i) begin
        mem_pending = 1;
        pend_addr   = req_addr_seen;
        pend_stale  = req_stale;
        pend_age    = 0;
        req_open    = 0;
      end else begin
        if (req_open) req_age++;
        if (mem_pending) pend_age++;
      end
    end
    prev_rst    = drv_rst;
    prev_fe     = drv_fe;
    drv_branch  = 1'b0;
    late_rvalid = 0;
  endtask

  task automatic runCycle();
    @(negedge clk);
    observeOutputs();
    applyStimulus();
    updateModel();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  task automatic resetDut(input logic [31:0] boot);
    drv_rst  = 1'b1;
    drv_boot = boot;
    runCycles(2);
    drv_rst  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base_req, base_pop;
    bit found;
    logic [31:0] tgt;

    rst_i = 1'b1; boot_addr_i = '0; fetch_enable_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; instr_rdata_i = '0; branch_i = 1'b0; branch_addr_i = '0;
    ready_i = 1'b0;

    // Sequential fetch from the boot address with one-cycle memory handshakes.
    gnt_delay = 0; rv_delay = 0; drv_fe = 1'b1; drv_ready = 1'b1;
    resetDut(32'h100);
    base_req = req_log.size(); base_pop = pop_log.size();
    runCycles(12);
    for (int i = 0; i < 3; i++) begin
      checkOutput("seq_req", log_at(req_log, base_req + i), 32'h100 + 32'(4 * i));
      checkOutput("seq_pop", log_at(pop_log, base_pop + i), 32'h100 + 32'(4 * i));
    end

    // Core stalled: the FIFO fills, then one pop allows exactly one more fetch.
    drv_ready = 1'b0;
    resetDut(32'h100);
    base_req = req_log.size();
    runCycles(20);
    checkOutput("full_req_count", req_log.size() - base_req, 2);
    checkOutput("full_req_low", instr_req_o, 1'b0);
    drv_ready = 1'b1; runCycle(); drv_ready = 1'b0;
    runCycles(15);
    checkOutput("one_pop_one_req", req_log.size() - base_req, 3);

    // Branch while waiting for the 0x108 response.
    gnt_delay = 0; rv_delay = 3; drv_ready = 1'b1;
    resetDut(32'h100);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      runCycle();
      if (mem_pending && pend_addr == 32'h108) found = 1;
    end
    checkOutput("wait_reached", found, 1'b1);
    base_req = req_log.size(); base_pop = pop_log.size();
    drv_branch = 1'b1; drv_baddr = 32'h203;
    runCycles(30);
    checkOutput("wait_branch_req", log_at(req_log, base_req), 32'h200);
    checkOutput("wait_branch_pop", log_at(pop_log, base_pop), 32'h200);

    // Branch during a request whose grant is held off for three cycles.
    gnt_delay = 3; rv_delay = 0;
    resetDut(32'h500);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      runCycle();
      if (req_open && req_age == 1) found = 1;
    end
    checkOutput("req_reached", found, 1'b1);
    base_req = req_log.size(); base_pop = pop_log.size();
    drv_branch = 1'b1; drv_baddr = 32'h4000;
    runCycles(30);
    checkOutput("req_branch_req", log_at(req_log, base_req), 32'h4000);
    checkOutput("req_branch_pop", log_at(pop_log, base_pop), 32'h4000);

    // Address wrap at the top of memory.
    gnt_delay = 0; rv_delay = 0;
    resetDut(32'hFFFF_FFFC);
    base_req = req_log.size(); base_pop = pop_log.size();
    runCycles(10);
    checkOutput("wrap_req0", log_at(req_log, base_req), 32'hFFFF_FFFC);
    checkOutput("wrap_req1", log_at(req_log, base_req + 1), 32'h0);
    checkOutput("wrap_pop1", log_at(pop_log, base_pop + 1), 32'h0);

    // Reset in the middle of a transaction, with the stale response arriving late.
    gnt_delay = 0; rv_delay = 5;
    resetDut(32'h300);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      runCycle();
      if (mem_pending) found = 1;
    end
    checkOutput("rst_wait_reached", found, 1'b1);
    drv_rst = 1'b1; runCycle(); drv_rst = 1'b0;
    base_req = req_log.size(); base_pop = pop_log.size();
    late_rvalid = 1; runCycle();
    runCycle();
    checkOutput("late_rvalid_dropped", valid_o, 1'b0);
    runCycles(20);
    checkOutput("rst_restart_req", log_at(req_log, base_req), 32'h300);
    checkOutput("rst_restart_pop", log_at(pop_log, base_pop), 32'h300);

    // Randomized traffic: memory latency, stalls, enables, branches and wrap-around targets.
    gnt_delay = -1; rv_delay = -1;
    resetDut({$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)});
    base_pop = pop_log.size();
    for (int i = 0; i < 3000; i++) begin
      drv_fe    = ($urandom_range(0, 9) != 0);
      drv_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) begin
        tgt = $urandom;
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
        drv_branch = 1'b1; drv_baddr = tgt;
      end
      runCycle();
    end
    checkOutput("random_progress", (pop_log.size() - base_pop) > 50, 1'b1);

    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, the number of fetched-instruction entries buffered toward the core (legal values 2..8).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  synchronous reset, active high.
REQ-005 boot_addr_i  input  32  first fetch address, sampled while rst_i=1.
REQ-006 fetch_enable_i  input  1  1 = new memory requests may be issued.
REQ-007 instr_req_o  output  1  memory request.
REQ-008 instr_addr_o  output  32  byte address of the request, word aligned.
REQ-009 instr_gnt_i  input  1  memory accepted the request this cycle.
REQ-010 instr_rvalid_i  input  1  instr_rdata_i is valid this cycle.
REQ-011 instr_rdata_i  input  32  fetched instruction word.
REQ-012 branch_i  input  1  redirect fetch, one-cycle pulse.
REQ-013 branch_addr_i  input  32  redirect target.
REQ-014 valid_o  output  1  instr_o and pc_o hold a buffered instruction.
REQ-015 ready_i  input  1  the core accepts the head entry when valid_o=1.
REQ-016 instr_o  output  32  instruction word of the head entry.
REQ-017 pc_o  output  32  address of the head entry.
REQ-018 busy_o  output  1  1 while a memory transaction is outstanding (state REQ or WAIT).

Function
REQ-019 The FSM SHALL have three states: IDLE (no transaction), REQ (instr_req_o=1, waiting for instr_gnt_i) and WAIT (granted, waiting for instr_rvalid_i).
REQ-020 Transitions:
- IDLE->REQ when fetch_enable_i=1 and free FIFO entries > 0.
- REQ->WAIT on instr_gnt_i=1.
- WAIT->REQ on instr_rvalid_i=1 if the issue condition still holds, else WAIT->IDLE.
REQ-021 At most one transaction SHALL be outstanding; a granted-but-unanswered request SHALL count as one occupied FIFO entry.
REQ-022 In REQ, instr_req_o and instr_addr_o SHALL stay stable until the grant, including when a branch or a deassertion of fetch_enable_i occurs.
REQ-023 The fetch address register SHALL advance by 4 on each grant, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-024 On instr_rvalid_i=1 without a pending discard, {instr_rdata_i, address} SHALL be written to the FIFO, and valid_o SHALL rise on the next cycle (latency 1 cycle).
REQ-025 A pop SHALL occur when valid_o & ready_i; in FIFO order, head first.
REQ-026 A simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-027 FIFO overflow SHALL be impossible by REQ-021; the FIFO SHALL NOT be popped while empty.
REQ-028 On branch_i=1:
- flush the FIFO, so valid_o=0 next cycle;
- set the fetch address to {branch_addr_i[31:2], 2'b00};
- if in REQ or WAIT, set the discard flag so the response of the outstanding transaction is dropped.
REQ-029 A branch in REQ SHALL complete the current handshake at the old address, drop its response, and issue the next request at the branch target.
REQ-030 branch_i and instr_rvalid_i in the same cycle SHALL drop the data.
REQ-031 branch_i and a pop in the same cycle: the flush SHALL win.
REQ-032 A branch in IDLE with fetch_enable_i=1 SHALL issue the request at the target on the next cycle.
REQ-033 fetch_enable_i=0 SHALL block only new requests; an outstanding transaction SHALL complete and its data SHALL be buffered.
REQ-034 instr_rdata_i SHALL be ignored when instr_rvalid_i=0; instr_rvalid_i in IDLE or REQ SHALL be ignored.

Reset
REQ-035 While rst_i=1:
- state = IDLE; instr_req_o = 0; busy_o = 0;
- FIFO empty; valid_o = 0; discard flag = 0;
- fetch address = {boot_addr_i[31:2], 2'b00}.
REQ-036 instr_o and pc_o SHALL be 0 while the FIFO is empty after reset.
REQ-037 Reset asserted mid-transaction SHALL abandon the transaction; a late instr_rvalid_i after reset SHALL be ignored.
REQ-038 The first request SHALL come no earlier than the cycle after rst_i falls.

Verification
REQ-039 boot_addr_i=0x100, fetch_enable_i=1, gnt and rvalid each 1 cycle after req, ready_i=1 -> requests to 0x100, 0x104, 0x108; pc_o and instr_o follow in order, valid_o 1 cycle after each rvalid.
REQ-040 ready_i=0 with FIFO_DEPTH=2 -> exactly 2 transactions, then instr_req_o stays 0; one pop -> one new request.
REQ-041 Branch to 0x203 while in WAIT at 0x108 -> the 0x108 response is dropped, the next request goes to 0x200, and valid_o=0 until the 0x200 data arrives.
REQ-042 Branch during REQ with gnt delayed 3 cycles -> instr_addr_o stays at the old address until the grant, its response is dropped, then a request to the target follows.
REQ-043 Fetch at 0xFFFFFFFC -> the next request goes to 0x00000000.
REQ-044 rst_i pulsed while in WAIT, rvalid arriving 1 cycle later -> no FIFO write, outputs at reset values, and fetch restarts at boot_addr_i.
